// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux-select arbiter.
package arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01
    } state_e;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Requester-side handshake bundle: master drives requests, slave is the arbiter.
interface mux_sel_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, sel, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, sel, busy, timeout
    );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set request after last_ptr, with mod-8 wrap.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    always_comb begin
        start = last_ptr + SEL_W'(1);
        rot   = '0;
        off   = '0;
        any   = 1'b0;
        // Rotate so bit 0 is the highest-priority requester, encode, then rotate back.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rot[i] = req[start + SEL_W'(i)];
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                off = SEL_W'(i);
            end
        end
        idx = start + off;
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux; grants are held
// until done, request drop, or MAX_HOLD cycles, with one idle cycle between grants.
module mux_sel_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_arbiter_if.slave   bus
);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic              rel_drop;
    logic              rel_limit;

    rr_pick8 u_pick (
        .req      (bus.req),
        .last_ptr (last_q),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    assign rel_drop  = !bus.req[sel_q];
    assign rel_limit = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (pick_any) begin
                    grant_d = N_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.done || rel_drop || rel_limit) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                    // Pulse only when the hold limit alone forced the release.
                    timeout_d = rel_limit && !bus.done && !rel_drop;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            last_q    <= SEL_W'(N_REQ - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed and randomized checks of mux_sel_arbiter against a cycle-level owner/hold model.
module tb_mux_sel_arbiter;
    import arb_pkg::*;

    localparam int unsigned MAX_HOLD = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: who owns the mux (-1 = nobody), how many cycles it has held it, last winner.
    int owner = -1;
    int held  = 0;
    int last  = 7;
    int m_sel = 0;
    bit m_to  = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] r;
        r = bus.req;
        if (rst) begin
            owner = -1; held = 0; m_sel = 0; last = 7; m_to = 1'b0;
        end else if (owner < 0) begin
            m_to = 1'b0;
            if (r != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    int c;
                    c = (last + k) % 8;
                    if (r[c]) begin
                        owner = c; m_sel = c; last = c; held = 1;
                        break;
                    end
                end
            end
        end else begin
            m_to = 1'b0;
            if (bus.done || !r[owner] || held == MAX_HOLD) begin
                m_to  = !bus.done && r[owner];
                owner = -1;
            end else begin
                held++;
            end
        end
    endtask

    task automatic cyc();
        logic [7:0] exp_g;
        @(posedge clk);
        model_edge();
        #1;
        exp_g = (owner < 0) ? 8'h00 : 8'(1 << owner);
        check("grant", bus.grant, exp_g);
        check("sel", 8'(bus.sel), 8'(m_sel));
        check("busy", 8'(bus.busy), 8'(owner >= 0));
        check("timeout", 8'(bus.timeout), 8'(m_to));
    endtask

    initial begin
        rst = 1'b1; bus.req = 8'h00; bus.done = 1'b0;
        cyc();
        check("rst_grant", bus.grant, 8'h00);
        check("rst_sel", 8'(bus.sel), 8'h00);
        check("rst_busy", 8'(bus.busy), 8'h00);
        check("rst_timeout", 8'(bus.timeout), 8'h00);

        // Single requester, released by done
        rst = 1'b0; bus.req = 8'h01;
        cyc();
        check("A_grant", bus.grant, 8'h01);
        check("A_busy", 8'(bus.busy), 8'h01);
        bus.done = 1'b1;
        cyc();
        check("A_rel", bus.grant, 8'h00);
        check("A_rel_busy", 8'(bus.busy), 8'h00);
        bus.done = 1'b0; bus.req = 8'h00;

        // All requesting: rotation 0..7,0 with an idle cycle between grants
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            cyc();
            check("B_sel", 8'(bus.sel), 8'(k % 8));
            check("B_grant", bus.grant, 8'(1 << (k % 8)));
            bus.done = 1'b1;
            cyc();
            check("B_gap", bus.grant, 8'h00);
            bus.done = 1'b0;
        end

        // Hold limit: exactly MAX_HOLD cycles then a timeout pulse
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.req = 8'h08;
        for (int k = 0; k < 15; k++) begin
            cyc();
            check("C_hold", bus.grant, 8'h08);
        end
        cyc();
        check("C_rel", bus.grant, 8'h00);
        check("C_timeout", 8'(bus.timeout), 8'h01);
        cyc();
        check("C_regrant", bus.grant, 8'h08);
        check("C_to_clear", 8'(bus.timeout), 8'h00);

        // Round-robin from last_ptr=2, release by request drop
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.req = 8'h04;
        cyc();
        check("D_first", bus.grant, 8'h04);
        bus.done = 1'b1; cyc(); bus.done = 1'b0;
        bus.req = 8'h24;
        cyc();
        check("D_grant5", bus.grant, 8'h20);
        check("D_sel5", 8'(bus.sel), 8'h05);
        bus.req = 8'h04;
        cyc();
        check("D_drop", bus.grant, 8'h00);
        check("D_drop_to", 8'(bus.timeout), 8'h00);
        cyc();
        check("D_next", bus.grant, 8'h04);

        // Reset in the middle of a grant
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.req = 8'h10;
        cyc();
        check("E_grant", bus.grant, 8'h10);
        rst = 1'b1; bus.req = 8'hFF;
        cyc();
        check("E_rst_grant", bus.grant, 8'h00);
        check("E_rst_busy", 8'(bus.busy), 8'h00);
        check("E_rst_to", 8'(bus.timeout), 8'h00);
        rst = 1'b0;
        cyc();
        check("E_after", bus.grant, 8'h01);

        // done coinciding with the hold limit, then done while idle
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.req = 8'h08;
        cyc();
        for (int k = 0; k < 14; k++) cyc();
        check("F_still", bus.grant, 8'h08);
        bus.done = 1'b1;
        cyc();
        check("F_rel", bus.grant, 8'h00);
        check("F_to", 8'(bus.timeout), 8'h00);
        bus.req = 8'h00;
        cyc();
        check("F_idle_done", 8'(bus.busy), 8'h00);
        bus.req = 8'h01;
        cyc();
        check("F_done_ignored", bus.grant, 8'h01);
        bus.done = 1'b0; bus.req = 8'h00;
        cyc();

        // Randomized traffic; requests change occasionally so hold limits are reached
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0)
                bus.req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
            bus.done = ($urandom_range(0, 11) == 0);
            rst      = ($urandom_range(0, 249) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
